mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 32 +++
 rtl/mem_bus_arbiter_if.sv | 44 ++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory line bus arbiter.
// Holds the memory command codes, arbiter FSM states and default bus geometry.
// Imported by the interface, the round-robin sub-module and the arbiter top.
package mem_bus_pkg;

  localparam int DEF_ADDR_BUS_SIZE = 14;  // line address (tag+set)
  localparam int DEF_DATA_BUS_SIZE = 16;  // bus beat width
  localparam int DEF_CTR_BUS_SIZE  = 2;   // memory command width
  localparam int DEF_LINE_BEATS    = 8;   // beats per 16-byte line
  localparam int DEF_TIMEOUT       = 255; // max idle cycles waiting on memory

  typedef enum logic [1:0] {
    CMD_NOP        = 2'd0,
    CMD_RESPONSE   = 2'd1,
    CMD_READ_LINE  = 2'd2,
    CMD_WRITE_LINE = 2'd3
  } mem_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

  // Only full-line reads and writes are legal requester commands.
  function automatic logic is_line_cmd(input logic [1:0] cmd);
    return (cmd == CMD_READ_LINE) || (cmd == CMD_WRITE_LINE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the line bus arbiter.
// Ports: req/req_cmd/req_addr/req_wdata in, gnt/wready/rdata/rvalid/done/err out,
//        mem_cmd/mem_addr/mem_wdata/mem_wvalid out, mem_rdata/mem_rvalid/mem_ack in.
// master = arbiter view, slave = requesters + memory model view.
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BUS_SIZE = DEF_ADDR_BUS_SIZE,
  parameter int DATA_BUS_SIZE = DEF_DATA_BUS_SIZE,
  parameter int CTR_BUS_SIZE  = DEF_CTR_BUS_SIZE
) ();

  logic [1:0]                 req;
  logic [2*CTR_BUS_SIZE-1:0]  req_cmd;
  logic [2*ADDR_BUS_SIZE-1:0] req_addr;
  logic [2*DATA_BUS_SIZE-1:0] req_wdata;
  logic [1:0]                 gnt;
  logic [1:0]                 wready;
  logic [DATA_BUS_SIZE-1:0]   rdata;
  logic [1:0]                 rvalid;
  logic [1:0]                 done;
  logic                       err;
  logic [CTR_BUS_SIZE-1:0]    mem_cmd;
  logic [ADDR_BUS_SIZE-1:0]   mem_addr;
  logic [DATA_BUS_SIZE-1:0]   mem_wdata;
  logic                       mem_wvalid;
  logic [DATA_BUS_SIZE-1:0]   mem_rdata;
  logic                       mem_rvalid;
  logic                       mem_ack;
  logic                       proto_err;

  modport master (
    input  req, req_cmd, req_addr, req_wdata, mem_rdata, mem_rvalid, mem_ack,
    output gnt, wready, rdata, rvalid, done, err,
           mem_cmd, mem_addr, mem_wdata, mem_wvalid, proto_err
  );

  modport slave (
    output req, req_cmd, req_addr, req_wdata, mem_rdata, mem_rvalid, mem_ack,
    input  gnt, wready, rdata, rvalid, done, err,
           mem_cmd, mem_addr, mem_wdata, mem_wvalid, proto_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: purely combinational, zero latency.
// No backpressure; the caller registers the pointer and the grant.
// Ports: req/rr_ptr in -> one-hot gnt; upd_vld/upd_idx in -> rr_ptr_nxt (loser of last turn).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       upd_vld,
  input  logic       upd_idx,
  output logic [1:0] gnt,
  output logic       rr_ptr_nxt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // After a completed turn the other requester gets priority.
    rr_ptr_nxt = upd_vld ? ~upd_idx : rr_ptr;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one line transaction at a time between dcache (port 0) and ifetch (port 1).
// Latency: req -> gnt +1 cycle -> mem_cmd +1 cycle; read beats forwarded 1 cycle after mem_rvalid.
// No backpressure towards memory: write beats stream on consecutive cycles, requesters wait on gnt/done.
// Ports: clk, rst_n (sync, active-low), bus (master modport: requester side and memory control side).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BUS_SIZE = DEF_ADDR_BUS_SIZE,
  parameter int DATA_BUS_SIZE = DEF_DATA_BUS_SIZE,
  parameter int CTR_BUS_SIZE  = DEF_CTR_BUS_SIZE,
  parameter int LINE_BEATS    = DEF_LINE_BEATS,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.master bus
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  arb_state_e               state_q, state_d;
  logic [1:0]               gnt_q, gnt_d;
  logic                     rr_ptr_q, rr_ptr_d;
  logic [CTR_BUS_SIZE-1:0]  cmd_q, cmd_d;
  logic [ADDR_BUS_SIZE-1:0] addr_q, addr_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     err_q, err_d;
  logic [1:0]               rvalid_q, rvalid_d;
  logic [DATA_BUS_SIZE-1:0] rdata_q, rdata_d;
  logic [CTR_BUS_SIZE-1:0]  mem_cmd_q, mem_cmd_d;
  logic [ADDR_BUS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                     proto_err_q, proto_err_d;

  logic [1:0]               arb_gnt;
  logic                     arb_idx;
  logic                     gnt_idx;
  logic [CTR_BUS_SIZE-1:0]  sel_cmd;
  logic [ADDR_BUS_SIZE-1:0] sel_addr;
  logic                     wait_rd;
  logic                     wait_wr;

  rr_arbiter2 u_rr (
    .req        (bus.req),
    .rr_ptr     (rr_ptr_q),
    .upd_vld    (state_q == ST_DONE),
    .upd_idx    (gnt_idx),
    .gnt        (arb_gnt),
    .rr_ptr_nxt (rr_ptr_d)
  );

  assign arb_idx  = arb_gnt[1];
  assign gnt_idx  = gnt_q[1];
  assign sel_cmd  = arb_idx ? bus.req_cmd[2*CTR_BUS_SIZE-1:CTR_BUS_SIZE]
                            : bus.req_cmd[CTR_BUS_SIZE-1:0];
  assign sel_addr = arb_idx ? bus.req_addr[2*ADDR_BUS_SIZE-1:ADDR_BUS_SIZE]
                            : bus.req_addr[ADDR_BUS_SIZE-1:0];
  assign wait_rd  = (state_q == ST_WAIT) && (cmd_q == CMD_READ_LINE);
  assign wait_wr  = (state_q == ST_WAIT) && (cmd_q == CMD_WRITE_LINE);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    mem_cmd_d   = CMD_NOP;
    mem_addr_d  = '0;
    proto_err_d = proto_err_q;

    // Memory responses are only legal in the matching wait phase; anything else is dropped and flagged.
    if ((bus.mem_rvalid && !wait_rd) || (bus.mem_ack && !wait_wr)) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          gnt_d   = arb_gnt;
          cmd_d   = sel_cmd;
          addr_d  = sel_addr;
          err_d   = 1'b0;
          beat_d  = '0;
          tmo_d   = '0;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        // Command and address are registered, so memory sees them the cycle after CMD.
        if (is_line_cmd(cmd_q)) begin
          mem_cmd_d  = cmd_q;
          mem_addr_d = addr_q;
          state_d    = (cmd_q == CMD_WRITE_LINE) ? ST_WDATA : ST_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_WDATA: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end

      ST_WAIT: begin
        if (wait_wr && bus.mem_ack) begin
          state_d = ST_DONE;
        end else if (wait_rd && bus.mem_rvalid) begin
          rvalid_d = gnt_q;
          rdata_d  = bus.mem_rdata;
          tmo_d    = '0;
          beat_d   = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end else if (tmo_q == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      rr_ptr_q    <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_cmd_q   <= CMD_NOP;
      mem_addr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Write beats pass straight from the granted requester to memory while in WDATA.
  assign bus.gnt        = gnt_q;
  assign bus.wready     = (state_q == ST_WDATA) ? gnt_q : 2'b00;
  assign bus.mem_wvalid = (state_q == ST_WDATA);
  assign bus.mem_wdata  = (state_q != ST_WDATA) ? '0 :
                          gnt_idx ? bus.req_wdata[2*DATA_BUS_SIZE-1:DATA_BUS_SIZE]
                                  : bus.req_wdata[DATA_BUS_SIZE-1:0];
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.done       = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign bus.err        = (state_q == ST_DONE) && err_q;
  assign bus.mem_cmd    = mem_cmd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus hand-written
// sequences for reset, simultaneous requests, mid-write reset and stray memory responses.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int TMO = 255;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .ADDR_BUS_SIZE (14),
    .DATA_BUS_SIZE (16),
    .CTR_BUS_SIZE  (2),
    .LINE_BEATS    (8),
    .TIMEOUT       (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [1:0] cmd;
    logic [13:0] addr;
    int         dly;     // cycles before each memory response; negative = memory never answers
    logic       exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction on a single port, starting from IDLE.
  task automatic run_txn(input int p, input logic [1:0] cmd, input logic [13:0] addr,
                         input int dly, input logic exp_err, input string tag);
    logic [1:0]  oh;
    logic [15:0] w;
    int          cnt;
    oh = 2'b01 << p;
    bus.req[p]                = 1'b1;
    bus.req_cmd[p*2 +: 2]     = cmd;
    bus.req_addr[p*14 +: 14]  = addr;
    bus.req_wdata[p*16 +: 16] = 16'hA000;
    tick();
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
    check({tag, "_cmd_pre"}, 32'(bus.mem_cmd), 32'(CMD_NOP));
    tick();
    if (cmd == CMD_READ_LINE || cmd == CMD_WRITE_LINE) begin
      check({tag, "_mem_cmd"}, 32'(bus.mem_cmd), 32'(cmd));
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(addr));
      if (cmd == CMD_WRITE_LINE) begin
        for (int b = 0; b < 8; b++) begin
          if (b == 1) check({tag, "_cmd_post"}, 32'(bus.mem_cmd), 32'(CMD_NOP));
          w = 16'(16'hA000 + b);
          check($sformatf("%s_wbeat%0d", tag, b),
                32'({bus.wready, bus.mem_wvalid, bus.mem_wdata}), 32'({oh, 1'b1, w}));
          bus.req_wdata[p*16 +: 16] = 16'(w + 16'd1);
          tick();
        end
        check({tag, "_wdata_end"}, 32'({bus.wready, bus.mem_wvalid}), 32'(0));
        repeat (dly) tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
      end else if (dly >= 0) begin
        for (int b = 0; b < 8; b++) begin
          repeat (dly) tick();
          w = 16'(16'h1111 * (b + 1));
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = w;
          tick();
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = 16'h0;
          if (b == 0) check({tag, "_cmd_post"}, 32'(bus.mem_cmd), 32'(CMD_NOP));
          check($sformatf("%s_rbeat%0d", tag, b),
                32'({bus.rvalid, bus.rdata}), 32'({oh, w}));
        end
      end else begin
        cnt = 0;
        while (bus.done == 2'b00 && cnt < 400) begin
          tick();
          cnt++;
        end
        check({tag, "_tmo_window"}, 32'(cnt >= TMO && cnt <= TMO + 2), 32'(1));
      end
    end else begin
      check({tag, "_no_mem_cmd"}, 32'(bus.mem_cmd), 32'(CMD_NOP));
    end
    check({tag, "_done"}, 32'(bus.done), 32'(oh));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_proto"}, 32'(bus.proto_err), 32'(0));
    bus.req[p]            = 1'b0;
    bus.req_cmd[p*2 +: 2] = CMD_NOP;
    tick();
    check({tag, "_release"}, 32'({bus.gnt, bus.done}), 32'(0));
  endtask

  // Both ports request together with bad commands; checks grant order only.
  task automatic pair_test(input int first, input string tag);
    logic [1:0] oh_a;
    logic [1:0] oh_b;
    oh_a = 2'b01 << first;
    oh_b = 2'b01 << (1 - first);
    bus.req     = 2'b11;
    bus.req_cmd = {CMD_NOP, CMD_NOP};
    tick();
    check({tag, "_gnt_a"}, 32'(bus.gnt), 32'(oh_a));
    tick();
    check({tag, "_done_a"}, 32'({bus.done, bus.err}), 32'({oh_a, 1'b1}));
    bus.req[first] = 1'b0;
    tick();
    check({tag, "_gap"}, 32'(bus.gnt), 32'(0));
    tick();
    check({tag, "_gnt_b"}, 32'(bus.gnt), 32'(oh_b));
    tick();
    check({tag, "_done_b"}, 32'({bus.done, bus.err}), 32'({oh_b, 1'b1}));
    bus.req = 2'b00;
    tick();
    check({tag, "_idle"}, 32'(bus.gnt), 32'(0));
  endtask

  initial begin
    int seen_done;
    n_vec = 0;
    n_err = 0;

    tbl[0] = '{port: 0, cmd: CMD_READ_LINE,  addr: 14'h01A3, dly: 0,   exp_err: 1'b0};
    tbl[1] = '{port: 1, cmd: CMD_WRITE_LINE, addr: 14'h3FFF, dly: 100, exp_err: 1'b0};
    tbl[2] = '{port: 0, cmd: CMD_WRITE_LINE, addr: 14'h0000, dly: 0,   exp_err: 1'b0};
    tbl[3] = '{port: 1, cmd: CMD_READ_LINE,  addr: 14'h02AA, dly: 2,   exp_err: 1'b0};
    tbl[4] = '{port: 0, cmd: CMD_NOP,        addr: 14'h0005, dly: 0,   exp_err: 1'b1};
    tbl[5] = '{port: 1, cmd: CMD_RESPONSE,   addr: 14'h0007, dly: 0,   exp_err: 1'b1};
    tbl[6] = '{port: 1, cmd: CMD_READ_LINE,  addr: 14'h0011, dly: -1,  exp_err: 1'b1};

    rst_n          = 1'b0;
    bus.req        = 2'b11;
    bus.req_cmd    = {CMD_READ_LINE, CMD_READ_LINE};
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_ack    = 1'b0;

    // Reset held three cycles with both ports requesting.
    repeat (3) tick();
    check("rst_gnt",       32'(bus.gnt),        32'(0));
    check("rst_wready",    32'(bus.wready),     32'(0));
    check("rst_rvalid",    32'(bus.rvalid),     32'(0));
    check("rst_done",      32'(bus.done),       32'(0));
    check("rst_err",       32'(bus.err),        32'(0));
    check("rst_mem_cmd",   32'(bus.mem_cmd),    32'(CMD_NOP));
    check("rst_mem_addr",  32'(bus.mem_addr),   32'(0));
    check("rst_mem_wdata", 32'(bus.mem_wdata),  32'(0));
    check("rst_wvalid",    32'(bus.mem_wvalid), 32'(0));
    check("rst_rdata",     32'(bus.rdata),      32'(0));
    check("rst_proto",     32'(bus.proto_err),  32'(0));
    bus.req     = 2'b00;
    bus.req_cmd = '0;
    rst_n       = 1'b1;
    tick();

    // Round-robin: port 0 first out of reset; after a lone port-0 turn, port 1 wins.
    pair_test(0, "pair0");
    run_txn(0, CMD_NOP, 14'h0001, 0, 1'b1, "solo0");
    pair_test(1, "pair1");

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].port, tbl[i].cmd, tbl[i].addr, tbl[i].dly, tbl[i].exp_err,
              $sformatf("v%0d", i));
    end

    // Reset while the fifth write beat is on the bus.
    bus.req[0]            = 1'b1;
    bus.req_cmd[1:0]      = CMD_WRITE_LINE;
    bus.req_addr[13:0]    = 14'h0123;
    bus.req_wdata[15:0]   = 16'hB000;
    repeat (6) tick();
    check("mid_wvalid", 32'(bus.mem_wvalid), 32'(1));
    rst_n = 1'b0;
    tick();
    check("mid_rst_outs",
          32'({bus.gnt, bus.wready, bus.mem_wvalid, bus.done, bus.mem_cmd}), 32'(0));
    bus.req     = 2'b00;
    bus.req_cmd = '0;
    rst_n       = 1'b1;
    seen_done   = 0;
    repeat (5) begin
      tick();
      if (bus.done != 2'b00 || bus.mem_cmd != CMD_NOP) seen_done = 1;
    end
    check("mid_rst_silent", 32'(seen_done), 32'(0));

    // Stray ack in IDLE sets the sticky flag, only reset clears it.
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("stray_ack_set", 32'(bus.proto_err), 32'(1));
    repeat (3) tick();
    check("stray_ack_hold", 32'(bus.proto_err), 32'(1));
    rst_n = 1'b0;
    tick();
    check("stray_ack_clr", 32'(bus.proto_err), 32'(0));
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
